// File: rtl/axis_bram_dma_if.sv
// axis_bram_dma_if: AXI4-Stream bundle for the bridge's read and write streams.
// master drives tvalid/tdata/tstrb/tlast, slave drives tready.
interface axis_bram_dma_if #(
   parameter int C_DATA_WIDTH = 64
);
   logic                      tvalid;
   logic                      tready;
   logic [C_DATA_WIDTH-1:0]   tdata;
   logic [C_DATA_WIDTH/8-1:0] tstrb;
   logic                      tlast;

   modport master (
      output tvalid, tdata, tstrb, tlast,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tlast,
      output tready
   );
endinterface

// File: rtl/axis_bram_dma.sv
// axis_bram_dma: AXIS <-> single-port BRAM bridge, credit-based read engine and fair arbiter.
// Define AXIS_BRAM_DMA_STRB_EN to drive bram_we from s_axis tstrb (default: all bytes written).
module axis_bram_dma #(
   parameter int C_ADDR_WIDTH      = 12,
   parameter int C_DATA_WIDTH      = 64,
   parameter int C_RD_FIFO_DEPTH   = 4,
   parameter int C_BRAM_RD_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ctrl_rd_start,
   input  logic [C_ADDR_WIDTH-1:0]   ctrl_rd_addr,
   input  logic [C_ADDR_WIDTH:0]     ctrl_rd_len,
   input  logic                      ctrl_wr_start,
   input  logic [C_ADDR_WIDTH-1:0]   ctrl_wr_addr,
   output logic                      stat_rd_busy,
   output logic                      stat_wr_busy,
   output logic                      stat_rd_done,
   output logic                      stat_wr_done,
   output logic [C_ADDR_WIDTH:0]     stat_wr_count,
   axis_bram_dma_if.slave            s_axis,
   axis_bram_dma_if.master           m_axis,
   output logic                      bram_clk,
   output logic                      bram_en,
   output logic [C_DATA_WIDTH/8-1:0] bram_we,
   output logic [C_ADDR_WIDTH-1:0]   bram_addr,
   output logic [C_DATA_WIDTH-1:0]   bram_din,
   input  logic [C_DATA_WIDTH-1:0]   bram_dout
);
   localparam int SW  = C_DATA_WIDTH / 8;
   localparam int LW  = C_ADDR_WIDTH + 1;
   localparam int PW  = $clog2(C_RD_FIFO_DEPTH);
   localparam int CW  = PW + 1;
   localparam int LAT = C_BRAM_RD_LATENCY;
   localparam logic [LW-1:0] CNT_MAX = {1'b1, {C_ADDR_WIDTH{1'b0}}};

   typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_FLUSH} rd_state_e;
   typedef enum logic {WR_IDLE, WR_RUN} wr_state_e;

   rd_state_e               rd_state_q, rd_state_d;
   logic [C_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           rd_iss_q, rd_iss_d;
   logic [LW-1:0]           rd_beat_q, rd_beat_d;
   logic                    rd_done_q, rd_done_d;
   logic [CW-1:0]           inflt_q, inflt_d;
   logic [CW-1:0]           fcnt_q, fcnt_d;
   logic [PW-1:0]           fwr_q, frd_q;
   logic [C_DATA_WIDTH-1:0] fmem_q [C_RD_FIFO_DEPTH];
   logic [LAT-1:0]          pipe_q;

   wr_state_e               wr_state_q, wr_state_d;
   logic [C_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]           wr_cnt_q, wr_cnt_d;
   logic                    wr_done_q, wr_done_d;
   logic                    prio_q, prio_d;

   logic          rd_req, wr_req, rd_gnt, wr_gnt;
   logic          push, pop, rd_vld;
   logic [CW:0]   credit;

   // fifo entries plus reads still in the BRAM pipe must fit the fifo
   assign credit = {1'b0, fcnt_q} + {1'b0, inflt_q};
   assign rd_req = (rd_state_q == RD_RUN) &&
                   (credit < (CW+1)'(C_RD_FIFO_DEPTH));
   assign wr_req = (wr_state_q == WR_RUN) && s_axis.tvalid;
   assign push   = pipe_q[LAT-1];
   assign rd_vld = (fcnt_q != '0);
   assign pop    = rd_vld && m_axis.tready;

   // prio_q=1: write wins the next contended cycle
   always_comb begin
      rd_gnt = 1'b0;
      wr_gnt = 1'b0;
      prio_d = prio_q;
      if (rd_req && wr_req) begin
         wr_gnt = prio_q;
         rd_gnt = !prio_q;
         prio_d = !prio_q;
      end else begin
         rd_gnt = rd_req;
         wr_gnt = wr_req;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_ptr_d   = rd_ptr_q;
      rd_iss_d   = rd_iss_q;
      rd_beat_d  = rd_beat_q;
      rd_done_d  = 1'b0;
      unique case (rd_state_q)
         RD_IDLE: begin
            if (ctrl_rd_start) begin
               if (ctrl_rd_len == '0) begin
                  rd_done_d = 1'b1;
               end else begin
                  rd_state_d = RD_RUN;
                  rd_ptr_d   = ctrl_rd_addr;
                  rd_iss_d   = ctrl_rd_len;
                  rd_beat_d  = ctrl_rd_len;
               end
            end
         end
         RD_RUN: begin
            if (rd_gnt) begin
               rd_ptr_d = rd_ptr_q + 1'b1;
               rd_iss_d = rd_iss_q - 1'b1;
               if (rd_iss_q == LW'(1)) rd_state_d = RD_FLUSH;
            end
         end
         RD_FLUSH: ;
         default: rd_state_d = RD_IDLE;
      endcase
      if (pop) begin
         rd_beat_d = rd_beat_q - 1'b1;
         if (rd_beat_q == LW'(1)) begin
            rd_state_d = RD_IDLE;
            rd_done_d  = 1'b1;
         end
      end
   end

   always_comb begin
      wr_state_d = wr_state_q;
      wr_ptr_d   = wr_ptr_q;
      wr_cnt_d   = wr_cnt_q;
      wr_done_d  = 1'b0;
      unique case (wr_state_q)
         WR_IDLE: begin
            if (ctrl_wr_start) begin
               wr_state_d = WR_RUN;
               wr_ptr_d   = ctrl_wr_addr;
               wr_cnt_d   = '0;
            end
         end
         WR_RUN: begin
            if (wr_gnt) begin
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (wr_cnt_q != CNT_MAX) wr_cnt_d = wr_cnt_q + 1'b1;
               if (s_axis.tlast) begin
                  wr_state_d = WR_IDLE;
                  wr_done_d  = 1'b1;
               end
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

   assign inflt_d = inflt_q + CW'(rd_gnt) - CW'(push);
   assign fcnt_d  = fcnt_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_state_q <= RD_IDLE;
         rd_ptr_q   <= '0;
         rd_iss_q   <= '0;
         rd_beat_q  <= '0;
         rd_done_q  <= 1'b0;
         inflt_q    <= '0;
         fcnt_q     <= '0;
         fwr_q      <= '0;
         frd_q      <= '0;
         pipe_q     <= '0;
         wr_state_q <= WR_IDLE;
         wr_ptr_q   <= '0;
         wr_cnt_q   <= '0;
         wr_done_q  <= 1'b0;
         prio_q     <= 1'b1;
      end else begin
         rd_state_q <= rd_state_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_iss_q   <= rd_iss_d;
         rd_beat_q  <= rd_beat_d;
         rd_done_q  <= rd_done_d;
         inflt_q    <= inflt_d;
         fcnt_q     <= fcnt_d;
         pipe_q     <= LAT'({pipe_q, rd_gnt});
         if (push) fwr_q <= fwr_q + 1'b1;
         if (pop)  frd_q <= frd_q + 1'b1;
         wr_state_q <= wr_state_d;
         wr_ptr_q   <= wr_ptr_d;
         wr_cnt_q   <= wr_cnt_d;
         wr_done_q  <= wr_done_d;
         prio_q     <= prio_d;
      end
   end

   // fifo storage needs no reset; validity lives in fcnt_q
   always_ff @(posedge clk) begin
      if (push) fmem_q[fwr_q] <= bram_dout;
   end

   assign bram_clk  = clk;
   assign bram_en   = rd_gnt || wr_gnt;
   assign bram_addr = wr_gnt ? wr_ptr_q : (rd_gnt ? rd_ptr_q : '0);
   assign bram_din  = s_axis.tdata;
`ifdef AXIS_BRAM_DMA_STRB_EN
   assign bram_we   = wr_gnt ? s_axis.tstrb : '0;
`else
   logic unused_strb;
   assign unused_strb = ^s_axis.tstrb;
   assign bram_we     = {SW{wr_gnt}};
`endif

   assign s_axis.tready = wr_gnt;
   assign m_axis.tvalid = rd_vld;
   assign m_axis.tdata  = rd_vld ? fmem_q[frd_q] : '0;
   assign m_axis.tstrb  = {SW{rd_vld}};
   assign m_axis.tlast  = rd_vld && (rd_beat_q == LW'(1));

   assign stat_rd_busy  = (rd_state_q != RD_IDLE);
   assign stat_wr_busy  = (wr_state_q != WR_IDLE);
   assign stat_rd_done  = rd_done_q;
   assign stat_wr_done  = wr_done_q;
   assign stat_wr_count = wr_cnt_q;
endmodule

// File: tb/tb_axis_bram_dma.sv
// tb_axis_bram_dma: directed stimulus with queue scoreboards for the M_AXIS and BRAM write paths.
// Word i of the bench BRAM is preloaded with the value i.
`timescale 1ns/1ps
module tb_axis_bram_dma;
   localparam int AW    = 12;
   localparam int DW    = 64;
   localparam int SW    = DW / 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          ctrl_rd_start = 1'b0;
   logic [AW-1:0] ctrl_rd_addr  = '0;
   logic [AW:0]   ctrl_rd_len   = '0;
   logic          ctrl_wr_start = 1'b0;
   logic [AW-1:0] ctrl_wr_addr  = '0;
   logic          stat_rd_busy, stat_wr_busy, stat_rd_done, stat_wr_done;
   logic [AW:0]   stat_wr_count;
   logic          bram_clk, bram_en;
   logic [SW-1:0] bram_we;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_din;
   logic [DW-1:0] bram_dout = '0;

   axis_bram_dma_if #(.C_DATA_WIDTH(DW)) s_axis_if ();
   axis_bram_dma_if #(.C_DATA_WIDTH(DW)) m_axis_if ();

   axis_bram_dma #(
      .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW),
      .C_RD_FIFO_DEPTH(DEPTH), .C_BRAM_RD_LATENCY(1)
   ) dut (
      .clk(clk), .reset(reset),
      .ctrl_rd_start(ctrl_rd_start), .ctrl_rd_addr(ctrl_rd_addr),
      .ctrl_rd_len(ctrl_rd_len),
      .ctrl_wr_start(ctrl_wr_start), .ctrl_wr_addr(ctrl_wr_addr),
      .stat_rd_busy(stat_rd_busy), .stat_wr_busy(stat_wr_busy),
      .stat_rd_done(stat_rd_done), .stat_wr_done(stat_wr_done),
      .stat_wr_count(stat_wr_count),
      .s_axis(s_axis_if), .m_axis(m_axis_if),
      .bram_clk(bram_clk), .bram_en(bram_en), .bram_we(bram_we),
      .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
   );

   // single-port BRAM, read-first, latency 1
   logic          preload = 1'b1;
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i);
      end else if (bram_en) begin
         for (int b = 0; b < SW; b++)
            if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
         bram_dout <= mem[bram_addr];
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } rbeat_t;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [SW-1:0] we;
   } wbeat_t;

   rbeat_t rq[$];
   wbeat_t wq[$];
   int     acc_log[$];
   bit     acc_en = 1'b0;
   int     beats_seen = 0;
   int     rd_dones = 0;
   int     wr_dones = 0;
   int     outst = 0;
   int     outst_max = 0;

   // monitor: sample between edges, compare against queued expectations
   always @(negedge clk) begin
      rbeat_t re;
      wbeat_t we;
      if (reset) begin
         outst = 0;
      end else begin
         if (m_axis_if.tvalid && m_axis_if.tready) begin
            beats_seen++;
            outst--;
            if (rq.size() == 0) begin
               chk("rd_unexpected_beat", m_axis_if.tdata, '1);
            end else begin
               re = rq.pop_front();
               chk("rd_data", m_axis_if.tdata, re.data);
               chk("rd_last", 64'(m_axis_if.tlast), 64'(re.last));
               chk("rd_strb", 64'(m_axis_if.tstrb), 64'hFF);
            end
         end
         if (bram_en && bram_we == '0) outst++;
         if (outst > outst_max) outst_max = outst;
         if (bram_en && bram_we != '0) begin
            if (wq.size() == 0) begin
               chk("wr_unexpected_beat", 64'(bram_addr), '1);
            end else begin
               we = wq.pop_front();
               chk("wr_addr", 64'(bram_addr), 64'(we.addr));
               chk("wr_data", bram_din, we.data);
               chk("wr_we", 64'(bram_we), 64'(we.we));
            end
         end
         if (stat_rd_done) rd_dones++;
         if (stat_wr_done) wr_dones++;
         if (acc_en)
            acc_log.push_back(bram_en ? ((bram_we != '0) ? 2 : 1) : 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rd_go(input logic [AW-1:0] a, input int len);
      for (int i = 0; i < len; i++)
         rq.push_back('{data: DW'(AW'(a + AW'(i))), last: (i == len - 1)});
      ctrl_rd_addr  = a;
      ctrl_rd_len   = (AW+1)'(len);
      ctrl_rd_start = 1'b1;
      cyc(1);
      ctrl_rd_start = 1'b0;
   endtask

   task automatic wait_rd_idle(input int budget, input bit toggle);
      int n = 0;
      while ((rq.size() != 0 || stat_rd_busy) && n < budget) begin
         cyc(1);
         n++;
         if (toggle && (n % 3 == 0)) m_axis_if.tready = ~m_axis_if.tready;
      end
      m_axis_if.tready = 1'b1;
      chk("rd_finish_in_budget", 64'(n < budget), 64'd1);
      cyc(2);
   endtask

   task automatic wr_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] strb, input bit last);
      int n = 0;
      s_axis_if.tvalid = 1'b1;
      s_axis_if.tdata  = d;
      s_axis_if.tstrb  = strb;
      s_axis_if.tlast  = last;
`ifdef AXIS_BRAM_DMA_STRB_EN
      wq.push_back('{addr: a, data: d, we: strb});
`else
      wq.push_back('{addr: a, data: d, we: '1});
`endif
      forever begin
         @(negedge clk);
         if (s_axis_if.tready || n > 200) break;
         n++;
      end
      chk("wr_accept_in_budget", 64'(n <= 200), 64'd1);
      @(posedge clk);
      #1;
      s_axis_if.tvalid = 1'b0;
      s_axis_if.tlast  = 1'b0;
   endtask

   task automatic wr_arm(input logic [AW-1:0] a);
      ctrl_wr_addr  = a;
      ctrl_wr_start = 1'b1;
      cyc(1);
      ctrl_wr_start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int d0, f, nacc, nalt, b0;
   initial begin
      s_axis_if.tvalid = 1'b0;
      s_axis_if.tdata  = '0;
      s_axis_if.tstrb  = '0;
      s_axis_if.tlast  = 1'b0;
      m_axis_if.tready = 1'b1;
      cyc(3);
      preload = 1'b0;
      chk("rst_m_tvalid", 64'(m_axis_if.tvalid), 0);
      chk("rst_m_tdata", m_axis_if.tdata, 0);
      chk("rst_m_tlast", 64'(m_axis_if.tlast), 0);
      chk("rst_m_tstrb", 64'(m_axis_if.tstrb), 0);
      chk("rst_s_tready", 64'(s_axis_if.tready), 0);
      chk("rst_bram_en", 64'(bram_en), 0);
      chk("rst_bram_we", 64'(bram_we), 0);
      chk("rst_bram_addr", 64'(bram_addr), 0);
      chk("rst_busy", 64'({stat_rd_busy, stat_wr_busy}), 0);
      chk("rst_done", 64'({stat_rd_done, stat_wr_done}), 0);
      chk("rst_wr_count", 64'(stat_wr_count), 0);
      reset = 1'b0;
      cyc(2);

      // zero-length read: no state change, done next cycle
      ctrl_rd_len = '0;
      ctrl_rd_start = 1'b1;
      cyc(1);
      ctrl_rd_start = 1'b0;
      chk("len0_done", 64'(stat_rd_done), 1);
      chk("len0_busy", 64'(stat_rd_busy), 0);
      cyc(2);

      // basic read with latency probe
      d0 = rd_dones;
      rd_go(12'h010, 8);
      chk("lat_en_c1", 64'(bram_en), 1);
      chk("lat_tvalid_c1", 64'(m_axis_if.tvalid), 0);
      cyc(1);
      chk("lat_tvalid_c2", 64'(m_axis_if.tvalid), 0);
      cyc(1);
      chk("lat_tvalid_c3", 64'(m_axis_if.tvalid), 1);
      wait_rd_idle(200, 1'b0);
      chk("rd8_done_pulses", 64'(rd_dones - d0), 1);

      // backpressure, plus a start pulse while busy that must be ignored
      d0 = rd_dones;
      rd_go(12'h100, 16);
      cyc(2);
      ctrl_rd_addr  = 12'h007;
      ctrl_rd_len   = 13'd3;
      ctrl_rd_start = 1'b1;
      cyc(1);
      ctrl_rd_start = 1'b0;
      wait_rd_idle(400, 1'b1);
      chk("bp_done_pulses", 64'(rd_dones - d0), 1);
      chk("bp_outstanding_max", 64'(outst_max <= DEPTH), 1);

      // strobed write over word 0 (preloaded with 0)
      d0 = wr_dones;
      wr_arm(12'h000);
      wr_beat(12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
      cyc(3);
`ifdef AXIS_BRAM_DMA_STRB_EN
      chk("strb_word0", mem[0], 64'h0000_0000_FFFF_FFFF);
`else
      chk("strb_word0", mem[0], 64'hFFFF_FFFF_FFFF_FFFF);
`endif
      chk("strb_wr_count", 64'(stat_wr_count), 1);

      // wrapping 4-beat write
      wr_arm(12'hFFE);
      chk("wr_count_cleared", 64'(stat_wr_count), 0);
      for (int k = 0; k < 4; k++)
         wr_beat(AW'(12'hFFE + k), 64'hDEAD_BEEF_0000_0000 + 64'(k), 8'hFF, k == 3);
      cyc(3);
      chk("wrap_mem_FFE", mem[12'hFFE], 64'hDEAD_BEEF_0000_0000);
      chk("wrap_mem_FFF", mem[12'hFFF], 64'hDEAD_BEEF_0000_0001);
      chk("wrap_mem_000", mem[12'h000], 64'hDEAD_BEEF_0000_0002);
      chk("wrap_mem_001", mem[12'h001], 64'hDEAD_BEEF_0000_0003);
      chk("wrap_wr_count", 64'(stat_wr_count), 4);
      chk("wr_done_pulses", 64'(wr_dones - d0), 2);
      chk("wr_busy_after", 64'(stat_wr_busy), 0);

      // contention: read and write armed in the same cycle
      d0 = rd_dones;
      b0 = wr_dones;
      acc_en = 1'b1;
      ctrl_rd_addr  = 12'h200;
      ctrl_rd_len   = 13'd8;
      ctrl_wr_addr  = 12'h300;
      for (int i = 0; i < 8; i++)
         rq.push_back('{data: DW'(12'h200 + i), last: (i == 7)});
      ctrl_rd_start = 1'b1;
      ctrl_wr_start = 1'b1;
      cyc(1);
      ctrl_rd_start = 1'b0;
      ctrl_wr_start = 1'b0;
      for (int k = 0; k < 8; k++)
         wr_beat(AW'(12'h300 + k), 64'hC0DE_0000_0000_0000 + 64'(k), 8'hFF, k == 7);
      wait_rd_idle(200, 1'b0);
      acc_en = 1'b0;
      f = -1;
      nacc = 0;
      nalt = 0;
      for (int k = 0; k < acc_log.size(); k++)
         if (acc_log[k] != 0 && f < 0) f = k;
      if (f >= 0 && f + 16 <= acc_log.size()) begin
         for (int k = f; k < f + 16; k++) begin
            if (acc_log[k] != 0) nacc++;
            if (k > f && acc_log[k] == acc_log[k-1]) nalt++;
         end
      end
      chk("cont_16_in_16", 64'(nacc), 16);
      chk("cont_alternate", 64'(nalt), 0);
      chk("cont_mem_307", mem[12'h307], 64'hC0DE_0000_0000_0007);
      chk("cont_wr_count", 64'(stat_wr_count), 8);
      chk("cont_rd_done", 64'(rd_dones - d0), 1);
      chk("cont_wr_done", 64'(wr_dones - b0), 1);

      // asynchronous reset after the third beat of a long read
      d0 = rd_dones;
      b0 = beats_seen;
      rd_go(12'h040, 16);
      for (int n = 0; n < 100 && beats_seen < b0 + 3; n++) @(posedge clk);
      chk("mid_three_beats", 64'(beats_seen - b0), 3);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_tvalid", 64'(m_axis_if.tvalid), 0);
      chk("mid_rst_tdata", m_axis_if.tdata, 0);
      chk("mid_rst_tlast", 64'(m_axis_if.tlast), 0);
      chk("mid_rst_bram_en", 64'(bram_en), 0);
      chk("mid_rst_busy", 64'(stat_rd_busy), 0);
      chk("mid_rst_wr_count", 64'(stat_wr_count), 0);
      rq.delete();
      cyc(3);
      reset = 1'b0;
      cyc(2);
      chk("mid_no_done", 64'(rd_dones - d0), 0);
      rd_go(12'h050, 2);
      wait_rd_idle(200, 1'b0);
      chk("post_rst_done", 64'(rd_dones - d0), 1);
      chk("wr_queue_drained", 64'(wq.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
